// File: rtl/wb_cache_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_cache_stage
// Purpose  : MEM/WB stage with write-back, write-allocate direct-mapped data
//            cache, word-serial refill/evict port and WB bubble/flush hold.
//            Define CACHE_STATS_EN to build the hit_cnt/miss_cnt counters.
// Revision : 1.0  initial release
// ============================================================================
module wb_cache_stage #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 3,
    parameter int TAG_ADDR_LEN  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bubbleW,
    input  logic        flushW,
    input  logic        wb_select,
    input  logic [2:0]  load_type,
    input  logic [3:0]  write_en,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] data_WB,
    output logic        miss,
    output logic        ref_signal,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int C_WORDS = 1 << LINE_ADDR_LEN;
    localparam int C_SETS  = 1 << SET_ADDR_LEN;
    localparam int C_ABITS = 2 + LINE_ADDR_LEN + SET_ADDR_LEN + TAG_ADDR_LEN;
    localparam logic [LINE_ADDR_LEN-1:0] C_BEAT_ONE  = LINE_ADDR_LEN'(1);
    localparam logic [LINE_ADDR_LEN-1:0] C_BEAT_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EVICT  = 2'd1,
        S_REFILL = 2'd2
    } state_t;

    state_t                    r_state;
    logic [LINE_ADDR_LEN-1:0]  r_beat;
    logic [SET_ADDR_LEN-1:0]   r_idx;
    logic [TAG_ADDR_LEN-1:0]   r_ntag;
    logic [C_SETS-1:0]         r_valid;
    logic [C_SETS-1:0]         r_dirty;
    logic [TAG_ADDR_LEN-1:0]   r_tag  [C_SETS];
    logic [31:0]               r_data [C_SETS*C_WORDS];

    logic        r_bubble, r_flush, r_wbsel_old;
    logic [31:0] r_addr_old, r_dwb_old, r_lword;
    logic [2:0]  r_ltype;
    logic [1:0]  r_lsb;

    logic                      w_store, w_access, w_hit, w_done, w_start, w_last;
    logic [SET_ADDR_LEN-1:0]   w_index;
    logic [TAG_ADDR_LEN-1:0]   w_tag, w_mtag;
    logic [LINE_ADDR_LEN-1:0]  w_off;
    logic [3:0]                w_bmask;
    logic [31:0]               w_sdata, w_ext;
    logic [7:0]                w_byte;
    logic [15:0]               w_half;

    assign w_store  = |write_en;
    assign w_access = wb_select | w_store;
    assign w_index  = addr[2+LINE_ADDR_LEN +: SET_ADDR_LEN];
    assign w_tag    = addr[2+LINE_ADDR_LEN+SET_ADDR_LEN +: TAG_ADDR_LEN];
    assign w_off    = addr[2 +: LINE_ADDR_LEN];
    assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_done   = (r_state == S_IDLE) && w_access && w_hit && !rst;
    assign w_start  = (r_state == S_IDLE) && w_access && !w_hit;
    assign w_last   = (r_beat == C_BEAT_LAST);
    assign w_bmask  = 4'(write_en << addr[1:0]);
    assign w_sdata  = wr_data << {addr[1:0], 3'b000};

    assign miss       = w_access && !(w_hit && (r_state == S_IDLE));
    assign ref_signal = w_done;
    assign mem_req    = (r_state != S_IDLE);
    assign mem_we     = (r_state == S_EVICT);
    assign w_mtag     = (r_state == S_EVICT) ? r_tag[r_idx] : r_ntag;
    assign mem_addr   = 32'({w_mtag, r_idx, r_beat, 2'b00});
    assign mem_wdata  = r_data[{r_idx, r_beat}];

    // Address bits above the cached space take no part in the lookup.
    generate
        if (C_ABITS < 32) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^addr[31:C_ABITS];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_idx   <= '0;
            r_ntag  <= '0;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_idx   <= w_index;
                        r_ntag  <= w_tag;
                        r_beat  <= '0;
                        r_state <= (r_valid[w_index] && r_dirty[w_index]) ? S_EVICT : S_REFILL;
                    end else if (w_done && w_store) begin
                        r_dirty[w_index] <= 1'b1;
                    end
                end
                S_EVICT: begin
                    if (mem_ack) begin
                        r_beat <= r_beat + C_BEAT_ONE;
                        if (w_last) r_state <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_ack) begin
                        r_beat <= r_beat + C_BEAT_ONE;
                        if (w_last) begin
                            r_tag[r_idx]   <= r_ntag;
                            r_valid[r_idx] <= 1'b1;
                            r_dirty[r_idx] <= 1'b0;
                            r_state        <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if ((r_state == S_REFILL) && mem_ack) begin
                r_data[{r_idx, r_beat}] <= mem_rdata;
            end else if (w_done && w_store) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_bmask[b]) r_data[{w_index, w_off}][8*b +: 8] <= w_sdata[8*b +: 8];
                end
            end
        end
    end

    // A store that also asserts wb_select writes back the address path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble    <= 1'b0;
            r_flush     <= 1'b0;
            r_wbsel_old <= 1'b0;
            r_addr_old  <= '0;
            r_dwb_old   <= '0;
            r_lword     <= '0;
            r_ltype     <= '0;
            r_lsb       <= '0;
        end else begin
            r_bubble    <= bubbleW;
            r_flush     <= flushW;
            r_wbsel_old <= wb_select & ~w_store;
            r_addr_old  <= addr;
            r_dwb_old   <= data_WB;
            r_lword     <= r_data[{w_index, w_off}];
            r_ltype     <= load_type;
            r_lsb       <= addr[1:0];
        end
    end

    assign w_byte = 8'(r_lword >> {r_lsb, 3'b000});
    assign w_half = 16'(r_lword >> {r_lsb[1], 4'b0000});

    always_comb begin
        w_ext = '0;
        case (r_ltype)
            3'd1:    w_ext = {{24{w_byte[7]}}, w_byte};
            3'd2:    w_ext = {{16{w_half[15]}}, w_half};
            3'd3:    w_ext = r_lword;
            3'd4:    w_ext = {24'd0, w_byte};
            3'd5:    w_ext = {16'd0, w_half};
            default: w_ext = '0;
        endcase
    end

    assign data_WB = r_bubble    ? r_dwb_old :
                     r_flush     ? 32'd0     :
                     r_wbsel_old ? w_ext     : r_addr_old;

`ifdef CACHE_STATS_EN
    logic        r_was_miss;
    logic [31:0] r_hit_cnt, r_miss_cnt;

    // The hit that completes a refilled access is not counted as a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_was_miss <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_start) begin
            r_was_miss <= 1'b1;
            r_miss_cnt <= r_miss_cnt + 32'd1;
        end else if (w_done) begin
            r_was_miss <= 1'b0;
            if (!r_was_miss) r_hit_cnt <= r_hit_cnt + 32'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_cache_stage.sv
`default_nettype none
// tb_wb_cache_stage: vector table, hand sequences and random accesses checked
// against a flat architectural memory plus a tag-only hit/miss predictor.
module tb_wb_cache_stage;
    localparam int L  = 3;
    localparam int S  = 3;
    localparam int T  = 10;
    localparam int NW = 1 << (L + S + T);

    logic        clk = 1'b0;
    logic        rst, bubbleW, flushW, wb_select, miss, ref_signal, mem_req, mem_we, mem_ack;
    logic [2:0]  load_type;
    logic [3:0]  write_en;
    logic [31:0] addr, wr_data, data_WB, mem_addr, mem_wdata, mem_rdata, hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    wb_cache_stage dut (
        .clk(clk), .rst(rst), .bubbleW(bubbleW), .flushW(flushW), .wb_select(wb_select),
        .load_type(load_type), .write_en(write_en), .addr(addr), .wr_data(wr_data),
        .data_WB(data_WB), .miss(miss), .ref_signal(ref_signal), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    logic [31:0] mem  [NW];
    logic [31:0] arch [NW];
    logic [T-1:0] mt [1<<S];
    logic        mv [1<<S];
    logic        md [1<<S];
    int          m_hit, m_miss, n_chk, n_pass, wbeats;
    logic [31:0] prev_exp, first_eaddr, first_edata;
    logic        ack_rand;

    typedef struct {
        logic        ws;
        logic [2:0]  lt;
        logic [3:0]  we;
        logic [31:0] a;
        logic [31:0] wd;
        logic        bub;
        logic        fl;
        logic [31:0] exp_data;
        logic        exp_miss;
        int          exp_wb;
    } vec_t;

    function automatic int unsigned widx(input logic [31:0] a);
        return 32'(a[L+S+T+1:2]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Memory side: acks every request (or ~3/4 of cycles when ack_rand).
    always @(negedge clk) begin
        if (mem_req && (!ack_rand || $urandom_range(3) != 0)) begin
            mem_ack = 1'b1;
            if (mem_we) begin
                if (wbeats == 0) begin
                    first_eaddr = mem_addr;
                    first_edata = mem_wdata;
                end
                wbeats++;
                chk("evict_data", mem_wdata, arch[widx(mem_addr)]);
                mem[widx(mem_addr)] = mem_wdata;
                mem_rdata = '0;
            end else begin
                mem_rdata = mem[widx(mem_addr)];
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = '0;
        end
    end

    task automatic model_reset();
        for (int i = 0; i < (1 << S); i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
            mt[i] = '0;
        end
        for (int w = 0; w < NW; w++) arch[w] = mem[w];
        m_hit    = 0;
        m_miss   = 0;
        prev_exp = '0;
    endtask

    function automatic logic pred_hit(input logic [31:0] a);
        return mv[a[L+S+1:L+2]] && (mt[a[L+S+1:L+2]] == a[L+S+T+1:L+S+2]);
    endfunction

    task automatic do_reset();
        rst = 1'b1; bubbleW = 0; flushW = 0; wb_select = 0; load_type = 0;
        write_en = 0; addr = 0; wr_data = 0;
        repeat (2) @(negedge clk);
        chk("rst_data_WB", data_WB, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_ref", 32'(ref_signal), 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic chk_cnt();
`ifdef CACHE_STATS_EN
        chk("hit_cnt", hit_cnt, 32'(m_hit));
        chk("miss_cnt", miss_cnt, 32'(m_miss));
`else
        chk("hit_cnt", hit_cnt, 32'd0);
        chk("miss_cnt", miss_cnt, 32'd0);
`endif
    endtask

    // One pipeline access: hold inputs until miss drops, then one more edge.
    task automatic access(input logic ws, input logic [2:0] lt, input logic [3:0] we,
                          input logic [31:0] a, input logic [31:0] wd, input logic bub,
                          input logic fl, output logic [31:0] got, output logic gmiss);
        logic acc, st, em, r;
        logic [S-1:0] s;
        logic [31:0] word, ext, exp;
        logic [7:0] bsel;
        logic [15:0] hsel;
        int ewb, n, w;
        acc = ws || (we != 0);
        st  = (we != 0);
        s   = a[L+S+1:L+2];
        w   = int'(widx(a));
        em  = acc && !pred_hit(a);
        ewb = (em && mv[s] && md[s]) ? (1 << L) : 0;
        if (em) begin
            m_miss++;
            mv[s] = 1'b1;
            mt[s] = a[L+S+T+1:L+S+2];
            md[s] = 1'b0;
        end else if (acc) begin
            m_hit++;
        end
        word = arch[w];
        bsel = word[8*a[1:0] +: 8];
        hsel = word[16*a[1] +: 16];
        case (lt)
            3'd1:    ext = {{24{bsel[7]}}, bsel};
            3'd2:    ext = {{16{hsel[15]}}, hsel};
            3'd3:    ext = word;
            3'd4:    ext = {24'd0, bsel};
            3'd5:    ext = {16'd0, hsel};
            default: ext = '0;
        endcase
        if (st) begin
            md[s] = 1'b1;
            for (int b = 0; b < 4; b++) begin
                int src;
                src = b - int'(a[1:0]);
                if (src >= 0 && we[src]) arch[w][8*b +: 8] = wd[8*src +: 8];
            end
        end
        exp = bub ? prev_exp : fl ? 32'd0 : (ws && !st) ? ext : a;
        prev_exp = exp;

        wb_select = ws; load_type = lt; write_en = we; addr = a; wr_data = wd;
        bubbleW = bub; flushW = fl;
        wbeats = 0;
        #1;
        gmiss = miss;
        n = 0;
        while (miss && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (miss) begin
            n_chk++;
            $display("FAIL miss_timeout: got miss=1 after %0d cycles, expected 0", n);
        end
        r = ref_signal;
        @(negedge clk);
        got = data_WB;
        chk("model_miss", 32'(gmiss), 32'(em));
        chk("model_ref", 32'(r), 32'(acc));
        chk("model_wbeats", 32'(wbeats), 32'(ewb));
        chk("model_data", got, exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tv [21];
        logic [31:0] got, rnd, a, wd;
        logic        gm, ws, bub, fl;
        logic [2:0]  lt;
        logic [3:0]  we;
        int          n;

        tv[0]  = '{1, 3, 4'h0, 32'h40,       0,            0, 0, 32'h00000000, 1, 0};
        tv[1]  = '{1, 3, 4'h0, 32'h44,       0,            0, 0, 32'h11111111, 0, 0};
        tv[2]  = '{0, 0, 4'h1, 32'h45,       32'h80,       0, 0, 32'h00000045, 0, 0};
        tv[3]  = '{1, 1, 4'h0, 32'h45,       0,            0, 0, 32'hFFFFFF80, 0, 0};
        tv[4]  = '{1, 4, 4'h0, 32'h45,       0,            0, 0, 32'h00000080, 0, 0};
        tv[5]  = '{1, 5, 4'h0, 32'h44,       0,            0, 0, 32'h00008011, 0, 0};
        tv[6]  = '{1, 2, 4'h0, 32'h46,       0,            0, 0, 32'h00001111, 0, 0};
        tv[7]  = '{1, 2, 4'h0, 32'h44,       0,            0, 0, 32'hFFFF8011, 0, 0};
        tv[8]  = '{1, 3, 4'h0, 32'h48,       0,            1, 0, 32'hFFFF8011, 0, 0};
        tv[9]  = '{1, 3, 4'h0, 32'h48,       0,            0, 0, 32'h22222222, 0, 0};
        tv[10] = '{1, 3, 4'h0, 32'h48,       0,            1, 1, 32'h22222222, 0, 0};
        tv[11] = '{1, 3, 4'h0, 32'h48,       0,            0, 1, 32'h00000000, 0, 0};
        tv[12] = '{0, 0, 4'h3, 32'h4A,       32'hABCD,     0, 0, 32'h0000004A, 0, 0};
        tv[13] = '{1, 3, 4'h0, 32'h48,       0,            0, 0, 32'hABCD2222, 0, 0};
        tv[14] = '{1, 3, 4'hF, 32'h40,       32'hDEADBEEF, 0, 0, 32'h00000040, 0, 0};
        tv[15] = '{1, 3, 4'h0, 32'h40,       0,            0, 0, 32'hDEADBEEF, 0, 0};
        tv[16] = '{0, 0, 4'h0, 32'h1234,     0,            0, 0, 32'h00001234, 0, 0};
        tv[17] = '{1, 3, 4'h0, 32'h140,      0,            0, 0, 32'hCAFEF00D, 1, 8};
        tv[18] = '{1, 3, 4'h0, 32'h44,       0,            0, 0, 32'h11118011, 1, 0};
        tv[19] = '{1, 0, 4'h0, 32'h44,       0,            0, 0, 32'h00000000, 0, 0};
        tv[20] = '{1, 3, 4'h0, 32'hFFFC0044, 0,            0, 0, 32'h11118011, 0, 0};

        n_chk = 0; n_pass = 0; wbeats = 0; ack_rand = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0; first_eaddr = '0; first_edata = '0;
        for (int w = 0; w < NW; w++)
            mem[w] = ((w >> 3) == 2) ? 32'((w & 7) * 32'h11111111) : $urandom();
        mem[32'h140 >> 2] = 32'hCAFEF00D;

        // Reset aborts a refill at beat 3; the access then misses again.
        do_reset();
        chk("idle_no_miss", 32'(miss), 32'd0);
        chk_cnt();
        wb_select = 1; load_type = 3; addr = 32'h40;
        #1;
        chk("first_miss_comb", 32'(miss), 32'd1);
        n = 0;
        while (!(mem_req && mem_addr == 32'h4C) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("refill_beat3_addr", mem_addr, 32'h4C);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_miss", 32'(miss), 32'd1);
        rst = 1'b0;
        model_reset();
        access(1, 3, 4'h0, 32'h40, 0, 0, 0, got, gm);
        chk("remiss_after_abort", 32'(gm), 32'd1);
        chk("remiss_data", got, 32'h0);

        // Vector table from a clean reset.
        do_reset();
        for (int i = 0; i < 21; i++) begin
            access(tv[i].ws, tv[i].lt, tv[i].we, tv[i].a, tv[i].wd, tv[i].bub, tv[i].fl, got, gm);
            chk($sformatf("vec%0d_data", i), got, tv[i].exp_data);
            chk($sformatf("vec%0d_miss", i), 32'(gm), 32'(tv[i].exp_miss));
            if (i == 1) chk_cnt();
            if (i == 17) chk($sformatf("vec%0d_evict_beats", i), 32'(wbeats), 32'(tv[i].exp_wb));
        end
        chk("evict_beat0_addr", first_eaddr, 32'h40);
        chk("evict_beat0_data", first_edata, 32'hDEADBEEF);
        chk_cnt();

        // Randomised accesses over 4 tags x all sets with irregular acks.
        ack_rand = 1'b1;
        for (int k = 0; k < 400; k++) begin
            rnd = $urandom();
            wd  = $urandom();
            a   = {rnd[31:18], 8'd0, rnd[9:8], rnd[7:2], 2'b00};
            ws = 0; lt = 0; we = 0;
            case ($urandom_range(5))
                0, 1, 2: begin
                    ws = 1;
                    lt = 3'($urandom_range(5));
                    if (lt == 1 || lt == 4) a[1:0] = rnd[17:16];
                    else if (lt == 2 || lt == 5) a[1] = rnd[17];
                end
                3, 4: begin
                    ws = rnd[0];
                    lt = 3'($urandom_range(5));
                    case ($urandom_range(2))
                        0: begin we = 4'h1; a[1:0] = rnd[17:16]; end
                        1: begin we = 4'h3; a[1] = rnd[17]; end
                        default: we = 4'hF;
                    endcase
                end
                default: a = rnd;
            endcase
            bub = ($urandom_range(7) == 0) && (!(ws || we != 0) || pred_hit(a));
            fl  = ($urandom_range(7) == 0);
            access(ws, lt, we, a, wd, bub, fl, got, gm);
            if (k % 50 == 49) chk_cnt();
        end
        ack_rand = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
